// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched word into the IF/ID register with a saturating fetch counter.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_if,
    input  logic                  flush_if,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [31:0]           imem_instruction,
    output logic [31:0]           ifid_instruction,
    output logic [ADDR_WIDTH-1:0] ifid_pc,
    output logic [ADDR_WIDTH-1:0] ifid_pc_plus4,
    output logic                  ifid_valid,
    output logic [15:0]           fetch_count
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = ~ADDR_WIDTH'(3);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] branch_pc;
    logic                  capture;

    assign imem_address = pc;
    assign pc_plus4     = pc + PC_STEP;
    // Redirect targets are word aligned; the low two target bits are discarded.
    assign branch_pc    = branch_target & ALIGN_MSK;
    assign capture      = !branch_taken && !flush_if && !stall_if;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= branch_pc;
        end else if (!stall_if) begin
            pc <= pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instruction <= '0;
            ifid_pc          <= '0;
            ifid_pc_plus4    <= '0;
            ifid_valid       <= 1'b0;
        end else if (branch_taken || flush_if) begin
            ifid_instruction <= '0;
            ifid_valid       <= 1'b0;
        end else if (!stall_if) begin
            ifid_instruction <= imem_instruction;
            ifid_pc          <= pc;
            ifid_pc_plus4    <= pc_plus4;
            ifid_valid       <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (capture && (fetch_count != '1)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: a queue of expected post-edge states is
// filled by the stimulus thread and drained by an independent monitor.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_if = 1'b0;
    logic        flush_if = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;
    logic [7:0]  imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] ifid_instruction;
    logic [7:0]  ifid_pc;
    logic [7:0]  ifid_pc_plus4;
    logic        ifid_valid;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
        logic [7:0]  ipc;
        logic [7:0]  ipc4;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference state of the stage.
    int          m_pc = 0;
    int          m_ipc = 0;
    int          m_ipc4 = 0;
    logic [31:0] m_instr = '0;
    logic        m_valid = 1'b0;
    int          m_cnt = 0;

    fetch_stage #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk(clk),
        .reset(reset),
        .stall_if(stall_if),
        .flush_if(flush_if),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_address(imem_address),
        .imem_instruction(imem_instruction),
        .ifid_instruction(ifid_instruction),
        .ifid_pc(ifid_pc),
        .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_valid(ifid_valid),
        .fetch_count(fetch_count)
    );

    assign imem_instruction = mem[imem_address[7:2]];

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one cycle of inputs, advance the reference model, queue the expectation.
    task automatic cycle(input bit rst, input bit stall, input bit flush,
                         input bit br, input int tgt);
        exp_t e;
        reset         = rst;
        stall_if      = stall;
        flush_if      = flush;
        branch_taken  = br;
        branch_target = 8'(tgt);
        if (rst) begin
            m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_instr = '0; m_valid = 1'b0; m_cnt = 0;
        end else begin
            if (br || flush) begin
                m_instr = '0;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = mem[m_pc / 4];
                m_ipc   = m_pc;
                m_ipc4  = (m_pc + 4) % 256;
                m_valid = 1'b1;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
            if (br) m_pc = tgt - (tgt % 4);
            else if (!stall) m_pc = (m_pc + 4) % 256;
        end
        e.pc = 8'(m_pc); e.instr = m_instr; e.ipc = 8'(m_ipc); e.ipc4 = 8'(m_ipc4);
        e.valid = m_valid; e.cnt = 16'(m_cnt);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("imem_address", 32'(imem_address), 32'(e.pc));
            chk("ifid_instruction", ifid_instruction, e.instr);
            chk("ifid_pc", 32'(ifid_pc), 32'(e.ipc));
            chk("ifid_pc_plus4", 32'(ifid_pc_plus4), 32'(e.ipc4));
            chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
            chk("fetch_count", 32'(fetch_count), 32'(e.cnt));
        end
    end

    initial begin
        logic [7:0] held_pc;
        int waited;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'hE3A01001;
        mem[1] = 32'hE3A02002;
        mem[2] = 32'hE0813002;

        // Reset and sequential run
        cycle(1, 0, 0, 0, 0);
        chk("rst_addr", 32'(imem_address), 32'h00);
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        run(1);
        chk("seq0_instr", ifid_instruction, 32'hE3A01001);
        chk("seq0_pc4", 32'(ifid_pc_plus4), 32'h04);
        run(1);
        chk("seq1_instr", ifid_instruction, 32'hE3A02002);
        chk("seq1_pc", 32'(ifid_pc), 32'h04);
        run(1);
        chk("seq2_instr", ifid_instruction, 32'hE0813002);
        chk("seq2_pc4", 32'(ifid_pc_plus4), 32'h0C);
        chk("seq_count", 32'(fetch_count), 32'd3);

        // Stall at pc 0x08
        cycle(1, 0, 0, 0, 0);
        run(2);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        chk("stall_addr", 32'(imem_address), 32'h08);
        chk("stall_ifid_pc", 32'(ifid_pc), 32'h04);
        chk("stall_count", 32'(fetch_count), 32'd2);
        run(1);
        chk("stall_resume_pc", 32'(ifid_pc), 32'h08);

        // Branch at pc 0x10 to unaligned 0x41
        cycle(1, 0, 0, 0, 0);
        run(4);
        cycle(0, 0, 0, 1, 8'h41);
        chk("br_valid", 32'(ifid_valid), 32'h0);
        chk("br_addr", 32'(imem_address), 32'h40);
        run(1);
        chk("br_tgt_pc", 32'(ifid_pc), 32'h40);
        chk("br_tgt_valid", 32'(ifid_valid), 32'h1);
        chk("br_count", 32'(fetch_count), 32'd5);

        // Wrap past 0xFC
        cycle(0, 0, 0, 1, 8'hF8);
        run(1);
        chk("wrap_pc0", 32'(ifid_pc), 32'hF8);
        run(1);
        chk("wrap_pc1", 32'(ifid_pc), 32'hFC);
        chk("wrap_pc4", 32'(ifid_pc_plus4), 32'h00);
        run(1);
        chk("wrap_pc2", 32'(ifid_pc), 32'h00);

        // Branch+stall, then flush+stall
        cycle(0, 1, 0, 1, 8'h80);
        chk("brstall_addr", 32'(imem_address), 32'h80);
        chk("brstall_valid", 32'(ifid_valid), 32'h0);
        run(2);
        held_pc = imem_address;
        cycle(0, 1, 1, 0, 0);
        chk("flstall_valid", 32'(ifid_valid), 32'h0);
        chk("flstall_addr", 32'(imem_address), 32'(held_pc));
        cycle(0, 0, 1, 0, 0);

        // Mid-run reset at pc 0x24
        cycle(1, 0, 0, 0, 0);
        run(9);
        chk("pre_rst_addr", 32'(imem_address), 32'h24);
        chk("pre_rst_count", 32'(fetch_count), 32'd9);
        cycle(1, 0, 0, 0, 0);
        chk("mid_rst_addr", 32'(imem_address), 32'h00);
        chk("mid_rst_instr", ifid_instruction, 32'h0);
        chk("mid_rst_count", 32'(fetch_count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 255)));
        end

        // Saturation of the fetch counter
        cycle(1, 0, 0, 0, 0);
        run(65534);
        chk("sat_pre", 32'(fetch_count), 32'hFFFE);
        run(3);
        chk("sat_hold", 32'(fetch_count), 32'hFFFF);

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
